// File: rtl/rootpower_loader.sv
// -----------------------------------------------------------------------------
// rootpower_loader
//   Writer side of the root-power RAM write path. Packs E/2 consecutive
//   (W, WQ) stream beats into one RAM row and drives the banked per-stage
//   write ports. Rows are written in stage-major, row-minor order. After the
//   last row the block waits out the interconnect write latency, then pulses
//   done.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   start, target        one-cycle load request and the RAM set to load
//   s_valid/s_ready      stream handshake; s_data = {WQ, W}, s_last = final beat
//   target_sel           registered target, stable while busy
//   ntt_input_W_*        per-stage row address / row data / lane enables (W)
//   ntt_input_WQ_*       same, for WQ (address and enables match W)
//   busy, done, err      load in progress, end-of-load pulse, sticky s_last error
//
// State table
//   IDLE  | waiting for start, s_ready low
//   FILL  | accepting beats into the lane buffer
//   WRITE | one-cycle row write on the current stage's slice
//   DRAIN | counting down the interconnect write latency
//   DONE  | one-cycle done pulse, busy already low
// -----------------------------------------------------------------------------
module rootpower_loader #(
  parameter int N              = 4096,
  parameter int E              = 8,
  parameter int LOGE           = 3,
  parameter int FSIZE          = 64,
  parameter int ROOT_POWER_NUM = 2,
  parameter int DRAIN_CYCLES   = 2,
  parameter int ADDR_W         = $clog2(N / (E / 2)),
  parameter int TGT_W          = (ROOT_POWER_NUM > 1) ? $clog2(ROOT_POWER_NUM) : 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic [TGT_W-1:0]               target,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [2*FSIZE-1:0]             s_data,
  input  logic                           s_last,
  output logic [TGT_W-1:0]               target_sel,
  output logic [LOGE*ADDR_W-1:0]         ntt_input_W_waddr,
  output logic [LOGE*(E/2)*FSIZE-1:0]    ntt_input_W_wdata,
  output logic [LOGE*(E/2)-1:0]          ntt_input_W_wren,
  output logic [LOGE*ADDR_W-1:0]         ntt_input_WQ_waddr,
  output logic [LOGE*(E/2)*FSIZE-1:0]    ntt_input_WQ_wdata,
  output logic [LOGE*(E/2)-1:0]          ntt_input_WQ_wren,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int HALF_E = E / 2;
  localparam int ROWS   = N / HALF_E;
  localparam int LANE_W = (HALF_E > 1) ? $clog2(HALF_E) : 1;
  localparam int STG_W  = (LOGE > 1) ? $clog2(LOGE) : 1;
  localparam int DRN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(HALF_E - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(ROWS - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(LOGE - 1);
  localparam logic [DRN_W-1:0]  DRN_LOAD  = DRN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [TGT_W-1:0]            target_q, target_d;
  logic [LANE_W-1:0]           lane_cnt_q, lane_cnt_d;
  logic [ADDR_W-1:0]           row_cnt_q, row_cnt_d;
  logic [STG_W-1:0]            stage_cnt_q, stage_cnt_d;
  logic [DRN_W-1:0]            drain_cnt_q, drain_cnt_d;
  logic [FSIZE-1:0]            lane_w_q  [HALF_E];
  logic [FSIZE-1:0]            lane_w_d  [HALF_E];
  logic [FSIZE-1:0]            lane_wq_q [HALF_E];
  logic [FSIZE-1:0]            lane_wq_d [HALF_E];
  logic                        s_ready_q, s_ready_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic [LOGE*ADDR_W-1:0]      waddr_q, waddr_d;
  logic [LOGE*HALF_E*FSIZE-1:0] wdata_w_q, wdata_w_d;
  logic [LOGE*HALF_E*FSIZE-1:0] wdata_wq_q, wdata_wq_d;
  logic [LOGE*HALF_E-1:0]      wren_q, wren_d;

  logic beat;
  logic last_lane;
  logic last_row;
  logic last_stage;
  logic final_beat;

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    lane_cnt_d  = lane_cnt_q;
    row_cnt_d   = row_cnt_q;
    stage_cnt_d = stage_cnt_q;
    drain_cnt_d = drain_cnt_q;
    lane_w_d    = lane_w_q;
    lane_wq_d   = lane_wq_q;
    s_ready_d   = s_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    waddr_d     = waddr_q;
    wdata_w_d   = wdata_w_q;
    wdata_wq_d  = wdata_wq_q;
    wren_d      = '0;

    // s_ready_q is only ever high in FILL, so it doubles as the state qualifier.
    beat       = s_ready_q && s_valid;
    last_lane  = (lane_cnt_q == LANE_LAST);
    last_row   = (row_cnt_q == ROW_LAST);
    last_stage = (stage_cnt_q == STG_LAST);
    final_beat = last_lane && last_row && last_stage;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          target_d    = target;
          lane_cnt_d  = '0;
          row_cnt_d   = '0;
          stage_cnt_d = '0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          s_ready_d   = 1'b1;
          state_d     = ST_FILL;
        end
      end

      ST_FILL: begin
        if (beat) begin
          lane_w_d[lane_cnt_q]  = s_data[FSIZE-1:0];
          lane_wq_d[lane_cnt_q] = s_data[2*FSIZE-1:FSIZE];
          if (s_last && !final_beat) begin
            // Early s_last aborts the load; the partially filled row is dropped.
            err_d       = 1'b1;
            s_ready_d   = 1'b0;
            lane_cnt_d  = '0;
            drain_cnt_d = DRN_LOAD;
            state_d     = ST_DRAIN;
          end else if (last_lane) begin
            if (final_beat && !s_last) begin
              err_d = 1'b1;
            end
            lane_cnt_d = '0;
            s_ready_d  = 1'b0;
            state_d    = ST_WRITE;
            // Write outputs are registered, so they are loaded here and are
            // visible during the WRITE cycle itself.
            for (int s = 0; s < LOGE; s++) begin
              waddr_d[s*ADDR_W +: ADDR_W] = row_cnt_q;
              wren_d[s*HALF_E +: HALF_E]  = (STG_W'(s) == stage_cnt_q) ?
                                            {HALF_E{1'b1}} : {HALF_E{1'b0}};
              for (int k = 0; k < HALF_E; k++) begin
                wdata_w_d[(s*HALF_E+k)*FSIZE +: FSIZE]  = lane_w_d[k];
                wdata_wq_d[(s*HALF_E+k)*FSIZE +: FSIZE] = lane_wq_d[k];
              end
            end
          end else begin
            lane_cnt_d = lane_cnt_q + LANE_W'(1);
          end
        end
      end

      ST_WRITE: begin
        if (last_row) begin
          row_cnt_d = '0;
          if (last_stage) begin
            drain_cnt_d = DRN_LOAD;
            state_d     = ST_DRAIN;
          end else begin
            stage_cnt_d = stage_cnt_q + STG_W'(1);
            s_ready_d   = 1'b1;
            state_d     = ST_FILL;
          end
        end else begin
          row_cnt_d = row_cnt_q + ADDR_W'(1);
          s_ready_d = 1'b1;
          state_d   = ST_FILL;
        end
      end

      ST_DRAIN: begin
        if (drain_cnt_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q - DRN_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      lane_cnt_q  <= '0;
      row_cnt_q   <= '0;
      stage_cnt_q <= '0;
      drain_cnt_q <= '0;
      for (int k = 0; k < HALF_E; k++) begin
        lane_w_q[k]  <= '0;
        lane_wq_q[k] <= '0;
      end
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_w_q   <= '0;
      wdata_wq_q  <= '0;
      wren_q      <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      lane_cnt_q  <= lane_cnt_d;
      row_cnt_q   <= row_cnt_d;
      stage_cnt_q <= stage_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      lane_w_q    <= lane_w_d;
      lane_wq_q   <= lane_wq_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      waddr_q     <= waddr_d;
      wdata_w_q   <= wdata_w_d;
      wdata_wq_q  <= wdata_wq_d;
      wren_q      <= wren_d;
    end
  end

  assign s_ready            = s_ready_q;
  assign target_sel         = target_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;
  assign ntt_input_W_waddr  = waddr_q;
  assign ntt_input_WQ_waddr = waddr_q;
  assign ntt_input_W_wdata  = wdata_w_q;
  assign ntt_input_WQ_wdata = wdata_wq_q;
  assign ntt_input_W_wren   = wren_q;
  assign ntt_input_WQ_wren  = wren_q;

endmodule

// File: doc/rootpower_loader.md
Name: rootpower_loader

Overview:
- Writer side of the root-power RAM write path. Takes a DMA stream of twiddle pairs (W, WQ) and packs E/2 consecutive words into one RAM row.
- Drives the banked per-stage write ports (waddr/wdata/wren for W and WQ) that the root-power interconnect fans out to the RAM selected by target_sel.
- Walks stage-major, row-minor order and waits out the interconnect write latency before reporting done.

Parameters:
N, 4096, polynomial degree
E, 8, butterfly radix; one row holds E/2 words
LOGE, 3, number of NTT stages per pass (logE)
FSIZE, 64, coefficient width
ROOT_POWER_NUM, 2, number of root-power RAM sets
DRAIN_CYCLES, 2, interconnect write pipeline depth (STAGE_ROOT_POWER)
ADDR_W, $clog2(N/(E/2)), row address width (derived)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle load request; ignored unless idle
target  in  $clog2(ROOT_POWER_NUM)  RAM set to load; sampled on accepted start
s_valid  in  1  stream beat valid
s_ready  out  1  stream beat accepted when s_valid&&s_ready
s_data  in  2*FSIZE  {WQ[FSIZE-1:0], W[FSIZE-1:0]}
s_last  in  1  marks final beat of the load
target_sel  out  $clog2(ROOT_POWER_NUM)  registered target, stable while busy
ntt_input_W_waddr  out  LOGE*ADDR_W  per-stage row address
ntt_input_W_wdata  out  LOGE*E/2*FSIZE  per-stage row data
ntt_input_W_wren  out  LOGE*E/2  per-stage lane enables
ntt_input_WQ_waddr  out  LOGE*ADDR_W  as W
ntt_input_WQ_wdata  out  LOGE*E/2*FSIZE  as W
ntt_input_WQ_wren  out  LOGE*E/2  as W
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of load
err  out  1  sticky s_last mismatch flag; cleared on next accepted start

Behaviour:
- Reset: all outputs 0, FSM IDLE, all counters 0. Reset mid-load abandons the load immediately, with no partial write after rstn deasserts.
- IDLE: s_ready=0. When start=1, latch target, clear lane/row/stage counters and err, set busy, go to FILL.
- FILL: s_ready=1.
  - Each accepted beat stores W and WQ into lane[lane_cnt].
  - When lane_cnt==E/2-1 on an accepted beat, go to WRITE and reset lane_cnt to 0.
- WRITE (exactly 1 cycle, s_ready=0):
  - waddr slices all = row_cnt.
  - wdata slices all = lane buffer; lane k sits at bits [k*FSIZE +: FSIZE].
  - wren: only slice stage_cnt is all-ones; every other slice is 0. W and WQ are driven identically.
  - Outside WRITE, every wren bit is 0; waddr/wdata hold their last values.
  - Then row_cnt++. At N/(E/2)-1 it wraps to 0 and stage_cnt++.
  - After row N/(E/2)-1 of stage LOGE-1, go to DRAIN; otherwise return to FILL.
- Throughput: E/2 beats per E/2+1 cycles.
- DRAIN: s_ready=0. Count DRAIN_CYCLES cycles, then go to DONE.
- DONE: done=1 for 1 cycle, busy drops in the same cycle, return to IDLE.
- s_last checking:
  - s_last=1 on any beat other than the final one (stage LOGE-1, last row, last lane): set err and go straight to DRAIN. The partial row is not written; rows already written remain.
  - Final beat without s_last: set err and complete normally.
- start while busy: ignored, with no effect on target or counters.
- Stalls: s_valid low in FILL stalls indefinitely, and counters hold.
- Total accepted beats for a clean load = LOGE*N. Total WRITE cycles = LOGE*N/(E/2).

Test Plan:
- N=16,E=8,LOGE=3: start target=1, stream 48 beats with W=i, WQ=i+1000, s_last on beat 47 -> 12 single-cycle writes. Write j has waddr=j%4 and wren slice j/4 = 4'b1111. Lane k of write j = 4j+k. target_sel=1 throughout. done pulses DRAIN_CYCLES+1 cycles after the last write. err=0.
- Random s_valid gaps (50%) on the same stream -> identical write sequence; wren never asserted outside WRITE; s_ready=0 during WRITE and DRAIN.
- s_last on beat 9 -> 2 writes (rows 0,1 of stage 0); beats 8-9 not written; err=1, then DRAIN and a done pulse. The next start clears err.
- No s_last on beat 47 -> all 12 writes issued, done pulses, err=1.
- start pulsed at cycle 5 of a busy load with target=0 -> target_sel stays 1 and the load completes unchanged.
- rstn low after 3 writes -> all outputs 0 asynchronously. After release: idle, s_ready=0, no further wren until a new start.
